// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with synchronous flush and NOP-control bubbles.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W   = 64,
  parameter int unsigned        CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic              r_out_valid;
  logic [1:0]        r_occupancy;
  logic              w_accept;
  logic              w_emit;
  logic              w_load_m_in;
  logic              w_clr_m;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic              r_in_ready;
  logic              w_load_s;
  logic              w_load_m_s;

  assign in_ready = r_in_ready;
`else
  assign in_ready = ~r_out_valid | out_ready;
`endif

  assign w_accept  = in_valid & in_ready;
  assign w_emit    = r_out_valid & out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_m_data;
  assign out_ctrl  = r_m_ctrl;
  assign occupancy = r_occupancy;

  // Next-state and register-load decisions; flush overrides every handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_clr_m     = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_load_s    = 1'b0;
    w_load_m_s  = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_clr_m     = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_load_m_in = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            w_state_nxt = ST_ONE;
            w_load_m_in = 1'b1;
          end else if (w_emit) begin
            w_state_nxt = ST_EMPTY;
            w_clr_m     = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_load_s    = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (w_emit) begin
            w_state_nxt = ST_ONE;
            w_load_m_s  = 1'b1;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_EMPTY;
          w_clr_m     = 1'b1;
        end
      endcase
    end
  end

  // State plus status outputs registered from the next state, so none has an input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_occupancy <= (w_state_nxt == ST_FULL) ? 2'd2 :
                     (w_state_nxt == ST_ONE)  ? 2'd1 : 2'd0;
    end
  end

  // Main register: control drops to NOP whenever the stage goes empty, payload is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data <= {DATA_W{1'b0}};
      r_m_ctrl <= CTRL_NOP;
    end else if (w_load_m_in) begin
      r_m_data <= in_data;
      r_m_ctrl <= in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
    end else if (w_load_m_s) begin
      r_m_data <= r_s_data;
      r_m_ctrl <= r_s_ctrl;
`endif
    end else if (w_clr_m) begin
      r_m_data <= r_m_data;
      r_m_ctrl <= CTRL_NOP;
    end else begin
      r_m_data <= r_m_data;
      r_m_ctrl <= r_m_ctrl;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid register catches the one entry in flight when downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_data   <= {DATA_W{1'b0}};
      r_s_ctrl   <= CTRL_NOP;
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_load_s) begin
        r_s_data <= in_data;
        r_s_ctrl <= in_ctrl;
      end else begin
        r_s_data <= r_s_data;
        r_s_ctrl <= r_s_ctrl;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model (both build variants).
module tb_pipe_stage_reg;
  localparam int DW = 16;
  localparam int CW = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit       SKID     = 1'b1;
  localparam bit [1:0] FULL_OCC = 2'd2;
`else
  localparam bit       SKID     = 1'b0;
  localparam bit [1:0] FULL_OCC = 2'd1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] m_last = '0;

  typedef struct packed {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [1:0]    eo;
    logic          er;
  } vec_t;
  vec_t tbl[10];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(4'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  function automatic logic model_ready();
    if (SKID) return (mq.size() < 2);
    return (mq.size() == 0) || (out_ready == 1'b1);
  endfunction

  task automatic model_check(input string tag);
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    ev = (mq.size() > 0);
    ed = ev ? mq[0].d : m_last;
    ec = ev ? mq[0].c : 4'h0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_out_data"},  32'(out_data),  32'(ed));
    chk({tag, "_out_ctrl"},  32'(out_ctrl),  32'(ec));
    chk({tag, "_occupancy"}, 32'(occupancy), 32'(mq.size()));
    chk({tag, "_in_ready"},  32'(in_ready),  32'(model_ready()));
  endtask

  // FIFO semantics: flush empties everything, otherwise emit pops and accept pushes.
  task automatic model_step();
    logic acc, emt;
    acc = in_valid && model_ready();
    emt = (mq.size() > 0) && out_ready;
    if (flush) begin
      mq.delete();
    end else begin
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back('{d: in_data, c: in_ctrl});
    end
    if (mq.size() > 0) m_last = mq[0].d;
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_last = '0;
  endtask

  // Skid build ends in FULL (AAAA in M, BBBB in S); plain build ends holding AAAA.
  task automatic fill();
    drive(1'b1, 16'hAAAA, 4'h1, SKID, 1'b0);
    @(negedge clk);
    adv();
    if (SKID) begin
      drive(1'b1, 16'hBBBB, 4'h2, 1'b0, 1'b0);
      @(negedge clk);
      adv();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0001, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 2'd0, 1'b1};
    tbl[1] = '{1'b1, 16'h0002, 4'h2, 1'b1, 1'b0, 1'b1, 16'h0001, 4'h1, 2'd1, 1'b1};
    tbl[2] = '{1'b1, 16'h0003, 4'h3, 1'b1, 1'b0, 1'b1, 16'h0002, 4'h2, 2'd1, 1'b1};
    tbl[3] = '{1'b1, 16'h0004, 4'h4, 1'b1, 1'b0, 1'b1, 16'h0003, 4'h3, 2'd1, 1'b1};
    tbl[4] = '{1'b1, 16'h0005, 4'h5, 1'b1, 1'b0, 1'b1, 16'h0004, 4'h4, 2'd1, 1'b1};
    tbl[5] = '{1'b1, 16'h1234, 4'hF, 1'b1, 1'b0, 1'b1, 16'h0005, 4'h5, 2'd1, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 16'h1234, 4'hF, 2'd1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 2'd0, 1'b1};
    tbl[8] = '{1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 2'd0, 1'b1};
    tbl[9] = '{1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 2'd0, 1'b1};

    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_ctrl",  32'(out_ctrl),  32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);

    // Streaming then bubble, identical in both builds.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_out_data", i),  32'(out_data),  32'(tbl[i].ed));
      chk($sformatf("tbl%0d_out_ctrl", i),  32'(out_ctrl),  32'(tbl[i].ec));
      chk($sformatf("tbl%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].er));
      adv();
    end

`ifdef PIPE_STAGE_SKID_EN
    // Stall lands the in-flight entry in the skid register, then drains in order.
    do_reset();
    drive(1'b1, 16'hAAAA, 4'h1, 1'b1, 1'b0);
    @(negedge clk);
    adv();
    drive(1'b1, 16'hBBBB, 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_rdy_still_high", 32'(in_ready), 32'h1);
    adv();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_occ2",     32'(occupancy), 32'h2);
    chk("stall_rdy_low",  32'(in_ready),  32'h0);
    chk("stall_hold_a",   32'(out_data),  32'hAAAA);
    adv();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_a",      32'(out_data), 32'hAAAA);
    chk("drain_a_ctrl", 32'(out_ctrl), 32'h1);
    adv();
    @(negedge clk);
    chk("drain_b",      32'(out_data),  32'hBBBB);
    chk("drain_b_ctrl", 32'(out_ctrl),  32'h2);
    chk("drain_b_occ",  32'(occupancy), 32'h1);
    adv();
    @(negedge clk);
    chk("drain_empty", 32'(out_valid), 32'h0);
`else
    // Plain build: in_ready follows out_ready combinationally while M is held.
    do_reset();
    drive(1'b1, 16'hAAAA, 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ns_rdy_empty", 32'(in_ready), 32'h1);
    adv();
    drive(1'b1, 16'hBBBB, 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    chk("ns_rdy_stall",  32'(in_ready),  32'h0);
    chk("ns_hold_a",     32'(out_data),  32'hAAAA);
    chk("ns_occ1",       32'(occupancy), 32'h1);
    adv();
    out_ready = 1'b1;
    #1;
    chk("ns_rdy_comb", 32'(in_ready), 32'h1);
    @(negedge clk);
    chk("ns_emit_a", 32'(out_data), 32'hAAAA);
    adv();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ns_got_b",      32'(out_data), 32'hBBBB);
    chk("ns_got_b_ctrl", 32'(out_ctrl), 32'h2);
    adv();
    @(negedge clk);
    chk("ns_empty", 32'(out_valid), 32'h0);
`endif

    // Flush while holding entries with a new input offered.
    do_reset();
    fill();
    drive(1'b1, 16'hCCCC, 4'h3, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_flush_occ", 32'(occupancy), 32'(FULL_OCC));
    adv();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("flush%0d_occ", i),   32'(occupancy), 32'h0);
      chk($sformatf("flush%0d_valid", i), 32'(out_valid), 32'h0);
      chk($sformatf("flush%0d_ctrl", i),  32'(out_ctrl),  32'h0);
      chk($sformatf("flush%0d_data", i),  32'(out_data),  32'hAAAA);
      chk($sformatf("flush%0d_rdy", i),   32'(in_ready),  32'h1);
      adv();
    end

    // Asynchronous reset between edges while holding entries.
    do_reset();
    fill();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data",  32'(out_data),  32'h0);
    chk("arst_ctrl",  32'(out_ctrl),  32'h0);
    chk("arst_occ",   32'(occupancy), 32'h0);
    chk("arst_rdy",   32'(in_ready),  32'h1);
    mq.delete();
    m_last = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the queue model, with rare flushes.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom),
            (i < 400) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0),
            $urandom_range(0, 19) == 0);
      @(negedge clk);
      model_check("rnd");
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, successor to the fixed per-field inter-stage latches (IF/ID, ID/IE, IE/MEM, MEM/WB). It carries an opaque payload bus and a control bus between two pipeline stages with a valid/ready handshake. It supports stall back-pressure, synchronous flush, and bubble insertion that forces control bits to a safe value. An optional skid buffer registers `in_ready` so that no combinational path runs from the downstream stall back to the upstream stage.

## Interface
- `DATA_W`, 64, payload width (instr, s_ext, operands, PC+2, etc. packed by the instantiating stage); held unchanged through bubbles
- `CTRL_W`, 8, control width (reg_en, mem_en, mem_wr, halt, etc.); replaced by `CTRL_NOP` whenever the output is not valid
- `CTRL_NOP`, {CTRL_W{1'b0}}, control value presented during bubbles and after reset
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `flush`  in  1  synchronous squash of all held entries (branch mispredict, exception)
- `in_valid`  in  1  upstream has an entry
- `in_ready`  out  1  stage can accept an entry this cycle
- `in_data`  in  DATA_W  upstream payload
- `in_ctrl`  in  CTRL_W  upstream control
- `out_valid`  out  1  entry available to downstream
- `out_ready`  in  1  downstream consumes the entry this cycle (0 = stall)
- `out_data`  out  DATA_W  payload of head entry
- `out_ctrl`  out  CTRL_W  control of head entry, or `CTRL_NOP` when `out_valid`=0
- `occupancy`  out  2  number of held entries (0..2)

## Operation
- Accept: `in_valid & in_ready`. Emit: `out_valid & out_ready`.
- State: main register M (drives the outputs) plus skid register S (skid build only). Each has a valid bit.
- States, with (M_valid, S_valid): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and must never occur.
- EMPTY: on accept, M <= input; go to ONE.
- ONE: accept and emit together, M <= input, stay in ONE. Emit only, go to EMPTY. Accept only (stall), S <= input, go to FULL.
- FULL: `in_ready`=0. On emit, M <= S, go to ONE. Otherwise hold.
- `flush`=1 has highest priority. At the next edge both valid bits clear (go to EMPTY). An entry accepted in the flush cycle is discarded but still counts as a completed handshake upstream. An emit in the flush cycle still completes downstream.
- Bubble: while `out_valid`=0, `out_ctrl`=`CTRL_NOP`. `out_data` holds its last loaded value.
- `occupancy` = M_valid + S_valid.
- Data and control are not modified in flight. Ordering is strictly FIFO.

## Timing
- Reset (async, immediate) values:
  - `out_valid`=0
  - `out_data`=0
  - `out_ctrl`=`CTRL_NOP`
  - `occupancy`=0
  - `in_ready`=1 (skid build); `in_ready`=1 (non-skid, since M empty)
- Reset deasserted mid-transfer: all entries are lost and no handshake completes on the reset cycle.
- Latency: an input accepted at edge N appears on `out_*` after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle when `out_ready`=1 continuously.
- Skid build: `in_ready` = ~S_valid, a pure register output. A stall asserted at cycle N drops `in_ready` at N+1 at the earliest. The one in-flight entry lands in S.
- No combinational path from any input to `out_valid`, `out_data` or `out_ctrl`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: 2-entry behaviour as above. `in_ready` is registered and `occupancy` ranges 0..2.
- `PIPE_STAGE_SKID_EN` undefined: no S register, FULL state unreachable, `occupancy` is 0..1.
  - `in_ready` = ~M_valid | out_ready (combinational).
  - Accept while M is held and `out_ready`=0 is impossible.
  - All other rules (flush, bubble, reset, latency) are unchanged.

## Test plan
- Streaming, skid build, `DATA_W`=16, `CTRL_W`=4, `out_ready`=1: inputs 0x0001..0x0005 on consecutive cycles -> outputs 0x0001..0x0005 one cycle later each, `occupancy` ≤1, `in_ready` stays 1.
- Stall:
  - Input 0xAAAA, then 0xBBBB with `out_ready`=0 from the second cycle -> `occupancy`=2, `in_ready`=0, `out_data`=0xAAAA held.
  - Release `out_ready` -> 0xAAAA, then 0xBBBB, emitted in order with no loss or duplication.
- Bubble: `in_valid`=0 for 3 cycles after 0x1234 with `in_ctrl`=0xF is consumed -> `out_valid`=0, `out_ctrl`=`CTRL_NOP` (0x0), `out_data`=0x1234.
- Flush in FULL while `in_valid`=1 -> next cycle `occupancy`=0, `out_valid`=0, `out_ctrl`=0. The flushed-cycle input never appears at the output.
- Async reset asserted between edges while FULL -> outputs immediately go to `out_valid`=0, `out_data`=0, `out_ctrl`=`CTRL_NOP`, `in_ready`=1, without waiting for a clock edge.
- Non-skid build, `out_ready`=0 with M full -> `in_ready`=0 in the same cycle. Raise `out_ready` -> `in_ready`=1 combinationally, and emit and accept both occur in that cycle.
